// File: rtl/periph_reg_fabric_pkg.sv
// Shared types and constants for the peripheral register fabric.
package periph_reg_fabric_pkg;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADCAB1E;

  // Request toward one register-bus target.
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  // Response from one register-bus target.
  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Port-index width; a single-port fabric still needs one bit to carry it.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_addr_dec.sv
// Combinational address decoder: lowest-index rule with start <= addr < end wins.
module periph_addr_dec
  import periph_reg_fabric_pkg::*;
#(
  parameter int unsigned NumPorts = 12
) (
  input  logic [31:0]                       addr_i,
  input  logic [NumPorts-1:0][31:0]         rule_start_i,
  input  logic [NumPorts-1:0][31:0]         rule_end_i,
  output logic [idx_w(int'(NumPorts))-1:0]  idx_o,
  output logic                              match_o
);

  localparam int IdxW = idx_w(int'(NumPorts));

  logic [NumPorts-1:0] hit;

  for (genvar i = 0; i < int'(NumPorts); i++) begin : g_hit
    assign hit[i] = (addr_i >= rule_start_i[i]) && (addr_i < rule_end_i[i]);
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    idx_o   = '0;
    match_o = 1'b0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx_o   = IdxW'(i);
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_reg_fabric.sv
// OBI-to-register-bus fabric: decodes one access at a time onto NumPorts targets,
// with per-access timeout and a saturating error counter.
module periph_reg_fabric
  import periph_reg_fabric_pkg::*;
#(
  parameter int unsigned NumPorts      = 12,
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrData       = ERR_DATA_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_i,
  input  logic [31:0]                       addr_i,
  input  logic                              we_i,
  input  logic [3:0]                        be_i,
  input  logic [31:0]                       wdata_i,
  output logic                              gnt_o,
  output logic                              rvalid_o,
  output logic [31:0]                       rdata_o,
  output logic                              err_o,
  input  logic [NumPorts-1:0][31:0]         rule_start_i,
  input  logic [NumPorts-1:0][31:0]         rule_end_i,
  output reg_req_t [NumPorts-1:0]           reg_req_o,
  input  reg_rsp_t [NumPorts-1:0]           reg_rsp_i,
  output logic                              timeout_o,
  output logic [idx_w(int'(NumPorts))-1:0]  timeout_port_o,
  output logic [7:0]                        err_count_o
);

  localparam int  IdxW = idx_w(int'(NumPorts));
  localparam int  CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit  ToEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  state_e state_q, state_d;

  logic [IdxW-1:0] dec_idx, idx_q;
  logic            dec_match;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [CntW-1:0] cnt_q;

  logic            cap, cnt_clr, cnt_inc, rsp_ld, rsp_err, to_hit;
  logic [31:0]     rsp_data;
  reg_rsp_t        sel_rsp;

  periph_addr_dec #(.NumPorts(NumPorts)) u_dec (
    .addr_i       (addr_i),
    .rule_start_i (rule_start_i),
    .rule_end_i   (rule_end_i),
    .idx_o        (dec_idx),
    .match_o      (dec_match)
  );

  assign sel_rsp  = reg_rsp_i[idx_q];
  assign rvalid_o = (state_q == ST_RESP);

  // Next state plus the strobes that steer the datapath registers.
  always_comb begin
    state_d  = state_q;
    gnt_o    = 1'b0;
    cap      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    rsp_ld   = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = ErrData;
    to_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          cap = 1'b1;
          if (dec_match) begin
            state_d = ST_ACCESS;
            cnt_clr = 1'b1;
          end else begin
            // Decode miss answers straight away without touching any target.
            state_d = ST_RESP;
            rsp_ld  = 1'b1;
            rsp_err = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_rsp.ready) begin
          // Ready beats a timeout landing in the same cycle.
          state_d  = ST_RESP;
          rsp_ld   = 1'b1;
          rsp_err  = sel_rsp.error;
          rsp_data = we_q ? 32'h0 : sel_rsp.rdata;
        end else if (ToEn && (cnt_q == CntLast)) begin
          state_d = ST_RESP;
          rsp_ld  = 1'b1;
          rsp_err = 1'b1;
          to_hit  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Latched request, wait counter, response and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      we_q           <= 1'b0;
      idx_q          <= '0;
      cnt_q          <= '0;
      rdata_o        <= '0;
      err_o          <= 1'b0;
      timeout_o      <= 1'b0;
      timeout_port_o <= '0;
      err_count_o    <= '0;
    end else begin
      timeout_o <= to_hit;
      if (cap) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
        we_q    <= we_i;
        idx_q   <= dec_idx;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (rsp_ld) begin
        rdata_o <= rsp_data;
        err_o   <= rsp_err;
        if (rsp_err && (err_count_o != 8'hFF)) err_count_o <= err_count_o + 8'd1;
      end
      if (to_hit) timeout_port_o <= idx_q;
    end
  end

  // Only the selected target sees a request, and only while in ACCESS.
  always_comb begin
    reg_req_o = '0;
    if (state_q == ST_ACCESS) begin
      reg_req_o[idx_q].valid = 1'b1;
      reg_req_o[idx_q].write = we_q;
      reg_req_o[idx_q].addr  = addr_q;
      reg_req_o[idx_q].wdata = wdata_q;
      reg_req_o[idx_q].wstrb = be_q;
    end
  end

endmodule
